// File: rtl/myreg_pkg.sv
// -----------------------------------------------------------------------------
// myreg_pkg
// Shared definitions for the register-port command controller:
//   - XLEN_DEFAULT : default data width of command/response and register port
//   - FUNCT_WRITE / FUNCT_READ : command codes (anything else is a NOP)
//   - state_t      : controller FSM state encoding
// -----------------------------------------------------------------------------
package myreg_pkg;

   localparam int XLEN_DEFAULT = 64;

   localparam logic [6:0] FUNCT_WRITE = 7'd0;
   localparam logic [6:0] FUNCT_READ  = 7'd1;

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_IDLE      = 3'd1,
      ST_WRITE     = 3'd2,
      ST_READ_REQ  = 3'd3,
      ST_READ_WAIT = 3'd4,
      ST_RESP      = 3'd5
   } state_t;

endpackage

// File: rtl/myreg_timeout.sv
// -----------------------------------------------------------------------------
// myreg_timeout
// Cycle counter bounding the wait for a register read return.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset
//   clear   : zero the counter (asserted the cycle before waiting starts)
//   run     : one waiting cycle elapses
//   expired : high during the TIMEOUT-th consecutive run cycle
// -----------------------------------------------------------------------------
module myreg_timeout #(
   parameter int TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] count_r;

   // Expiry is decoded from the count so it lines up with the waiting cycle itself.
   assign expired = run & (count_r == LAST);

   // Count waiting cycles; saturate at LAST so a stalled run never wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= {CW{1'b0}};
      end else if (clear) begin
         count_r <= {CW{1'b0}};
      end else if (run && !expired) begin
         count_r <= count_r + ONE;
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/myreg_ctrl.sv
// -----------------------------------------------------------------------------
// myreg_ctrl
// Accepts WRITE/READ/NOP commands and drives a simple register port, returning
// an optional tagged response.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready          : command handshake (ready only in IDLE)
//   cmd_funct, cmd_rd, cmd_xd    : command code, response tag, response wanted
//   cmd_rs1                      : write data
//   resp_valid/resp_ready        : response handshake
//   resp_rd, resp_data           : response tag and data
//   busy                         : high in every state except IDLE
//   err_timeout                  : sticky read-timeout flag
//   reg_enable                   : one-cycle init strobe after reset
//   reg_rqvalid, reg_wren        : register read request / write enable
//   reg_wrdata                   : register write data (holds last write)
//   reg_rdvalid, reg_rddata      : register read return
// -----------------------------------------------------------------------------
module myreg_ctrl
   import myreg_pkg::*;
#(
   parameter int XLEN    = XLEN_DEFAULT,
   parameter int TIMEOUT = 15
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [6:0]      cmd_funct,
   input  logic [4:0]      cmd_rd,
   input  logic            cmd_xd,
   input  logic [XLEN-1:0] cmd_rs1,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [4:0]      resp_rd,
   output logic [XLEN-1:0] resp_data,
   output logic            busy,
   output logic            err_timeout,
   output logic            reg_enable,
   output logic            reg_rqvalid,
   output logic            reg_wren,
   output logic [XLEN-1:0] reg_wrdata,
   input  logic            reg_rdvalid,
   input  logic [XLEN-1:0] reg_rddata
);

   state_t          state_r;
   logic [4:0]      rd_r;
   logic            xd_r;
   logic [XLEN-1:0] data_r;
   logic [XLEN-1:0] wrdata_r;
   logic            err_r;
   logic            live_s;
   logic            expired_s;

   // Outputs are pure decodes of registers; reset forces them low so nothing
   // leaks while the INIT state is already loaded but reset is still held.
   assign live_s      = ~reset;
   assign cmd_ready   = live_s & (state_r == ST_IDLE);
   assign busy        = live_s & (state_r != ST_IDLE);
   assign reg_enable  = live_s & (state_r == ST_INIT);
   assign reg_wren    = live_s & (state_r == ST_WRITE);
   assign reg_rqvalid = live_s & (state_r == ST_READ_REQ);
   assign resp_valid  = live_s & (state_r == ST_RESP);
   assign resp_rd     = rd_r & {5{live_s}};
   assign resp_data   = data_r & {XLEN{live_s}};
   assign reg_wrdata  = wrdata_r & {XLEN{live_s}};
   assign err_timeout = err_r;

   // Counter is zeroed during READ_REQ so the first READ_WAIT cycle counts as one.
   myreg_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (state_r == ST_READ_REQ),
      .run     (state_r == ST_READ_WAIT),
      .expired (expired_s)
   );

   // Controller FSM with latched command fields and response data.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r  <= ST_INIT;
         rd_r     <= 5'd0;
         xd_r     <= 1'b0;
         data_r   <= {XLEN{1'b0}};
         wrdata_r <= {XLEN{1'b0}};
         err_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               state_r <= ST_IDLE;
            end
            ST_IDLE: begin
               if (cmd_valid) begin
                  rd_r <= cmd_rd;
                  xd_r <= cmd_xd;
                  if (cmd_funct == FUNCT_WRITE) begin
                     wrdata_r <= cmd_rs1;
                     data_r   <= cmd_rs1;
                     state_r  <= ST_WRITE;
                  end else if (cmd_funct == FUNCT_READ) begin
                     state_r <= ST_READ_REQ;
                  end else begin
                     // NOP: no register activity, zero response data.
                     data_r  <= {XLEN{1'b0}};
                     state_r <= cmd_xd ? ST_RESP : ST_IDLE;
                  end
               end
            end
            ST_WRITE: begin
               state_r <= xd_r ? ST_RESP : ST_IDLE;
            end
            ST_READ_REQ: begin
               state_r <= ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
               // A return in the expiry cycle wins over the timeout.
               if (reg_rdvalid) begin
                  data_r  <= reg_rddata;
                  state_r <= xd_r ? ST_RESP : ST_IDLE;
               end else if (expired_s) begin
                  data_r  <= {XLEN{1'b1}};
                  err_r   <= 1'b1;
                  state_r <= xd_r ? ST_RESP : ST_IDLE;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_myreg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_myreg_ctrl
// Directed stimulus with a response scoreboard: expected responses are queued
// when a command is issued and popped by a monitor on each resp handshake.
// A small register model answers read requests one cycle after rqvalid.
// -----------------------------------------------------------------------------
module tb_myreg_ctrl;

   localparam int XLEN = 64;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [6:0]      cmd_funct = 7'd0;
   logic [4:0]      cmd_rd = 5'd0;
   logic            cmd_xd = 1'b0;
   logic [XLEN-1:0] cmd_rs1 = 64'd0;
   logic            resp_valid;
   logic            resp_ready = 1'b1;
   logic [4:0]      resp_rd;
   logic [XLEN-1:0] resp_data;
   logic            busy;
   logic            err_timeout;
   logic            reg_enable;
   logic            reg_rqvalid;
   logic            reg_wren;
   logic [XLEN-1:0] reg_wrdata;
   logic            reg_rdvalid = 1'b0;
   logic [XLEN-1:0] reg_rddata = 64'd0;

   myreg_ctrl #(
      .XLEN    (XLEN),
      .TIMEOUT (15)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_funct   (cmd_funct),
      .cmd_rd      (cmd_rd),
      .cmd_xd      (cmd_xd),
      .cmd_rs1     (cmd_rs1),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rd     (resp_rd),
      .resp_data   (resp_data),
      .busy        (busy),
      .err_timeout (err_timeout),
      .reg_enable  (reg_enable),
      .reg_rqvalid (reg_rqvalid),
      .reg_wren    (reg_wren),
      .reg_wrdata  (reg_wrdata),
      .reg_rdvalid (reg_rdvalid),
      .reg_rddata  (reg_rddata)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          wren_cnt = 0;
   int          rq_cnt = 0;
   int          en_cnt = 0;
   int          overlap_cnt = 0;
   logic        model_respond = 1'b1;
   logic        inj_rdvalid = 1'b0;
   logic        pend = 1'b0;
   logic [63:0] pend_data = 64'd0;
   logic [63:0] mem = 64'd0;
   logic        stall_r = 1'b0;
   logic [4:0]  stall_rd = 5'd0;
   logic [63:0] stall_data = 64'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one command; returns #1 after the accepting edge.
   task automatic issue(input logic [6:0] f, input logic [4:0] rd, input logic xd,
                        input logic [63:0] rs1);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL cmd_ready_wait: got cmd_ready=0 after %0d cycles, expected 1", n);
      end
      cmd_valid = 1'b1;
      cmd_funct = f;
      cmd_rd    = rd;
      cmd_xd    = xd;
      cmd_rs1   = rs1;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Register model: stores writes, answers a read request one cycle later.
   always @(negedge clock) begin
      if (reg_wren) mem = reg_wrdata;
      reg_rdvalid = pend | inj_rdvalid;
      reg_rddata  = pend ? pend_data : 64'h5A5A_5A5A_5A5A_5A5A;
      pend        = reg_rqvalid & model_respond;
      pend_data   = mem;
   end

   // Monitor: activity counters, response scoreboard, backpressure stability.
   always @(negedge clock) begin
      if (reset) begin
         stall_r = 1'b0;
      end else begin
         if (reg_wren) wren_cnt++;
         if (reg_rqvalid) rq_cnt++;
         if (reg_enable) en_cnt++;
         if (reg_wren && reg_rqvalid) overlap_cnt++;
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: got rd=%0d data=%h, expected no response",
                        resp_rd, resp_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("resp_rd", 64'(resp_rd), 64'(mon_e.rd));
               chk("resp_data", resp_data, mon_e.data);
            end
         end
         if (stall_r) begin
            chk("stall_valid", 64'(resp_valid), 64'd1);
            chk("stall_rd", 64'(resp_rd), 64'(stall_rd));
            chk("stall_data", resp_data, stall_data);
         end
         stall_r    = resp_valid & ~resp_ready;
         stall_rd   = resp_rd;
         stall_data = resp_data;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int r0;
      int n;

      // Reset: all outputs low.
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_ctrl", 64'({cmd_ready, resp_valid, busy, reg_enable, reg_rqvalid, reg_wren, err_timeout}), 64'd0);
      chk("rst_resp_rd", 64'(resp_rd), 64'd0);
      chk("rst_resp_data", resp_data, 64'd0);
      chk("rst_wrdata", reg_wrdata, 64'd0);

      // Release: one INIT cycle with reg_enable, then IDLE.
      reset = 1'b0;
      #1;
      chk("init_enable", 64'(reg_enable), 64'd1);
      chk("init_ready", 64'(cmd_ready), 64'd0);
      chk("init_busy", 64'(busy), 64'd1);
      tick();
      chk("idle_enable", 64'(reg_enable), 64'd0);
      chk("idle_ready", 64'(cmd_ready), 64'd1);
      chk("idle_busy", 64'(busy), 64'd0);

      // WRITE xd=1, rd=5.
      exp_q.push_back('{rd: 5'd5, data: 64'hDEADBEEF_00000001});
      issue(7'd0, 5'd5, 1'b1, 64'hDEADBEEF_00000001);
      chk("wr_wren", 64'(reg_wren), 64'd1);
      chk("wr_rqvalid", 64'(reg_rqvalid), 64'd0);
      chk("wr_wrdata", reg_wrdata, 64'hDEADBEEF_00000001);
      tick();
      chk("wr_resp_valid", 64'(resp_valid), 64'd1);
      tick();

      // READ xd=1, rd=7: response visible 3 cycles after acceptance.
      exp_q.push_back('{rd: 5'd7, data: 64'hDEADBEEF_00000001});
      issue(7'd1, 5'd7, 1'b1, 64'd0);
      chk("rd_rqvalid", 64'(reg_rqvalid), 64'd1);
      chk("rd_wren", 64'(reg_wren), 64'd0);
      tick();
      chk("rd_wait_valid", 64'(resp_valid), 64'd0);
      tick();
      chk("rd_latency_valid", 64'(resp_valid), 64'd1);
      chk("rd_latency_rd", 64'(resp_rd), 64'd7);
      tick();

      // Read timeout: no return, 15 waiting cycles.
      model_respond = 1'b0;
      exp_q.push_back('{rd: 5'd9, data: 64'hFFFFFFFF_FFFFFFFF});
      issue(7'd1, 5'd9, 1'b1, 64'd0);
      repeat (15) tick();
      chk("tmo_early_valid", 64'(resp_valid), 64'd0);
      chk("tmo_early_err", 64'(err_timeout), 64'd0);
      tick();
      chk("tmo_valid", 64'(resp_valid), 64'd1);
      chk("tmo_err", 64'(err_timeout), 64'd1);
      tick();
      model_respond = 1'b1;

      // Backpressure: resp_ready low for 4 cycles of RESP.
      resp_ready = 1'b0;
      exp_q.push_back('{rd: 5'd12, data: 64'h01234567_89ABCDEF});
      issue(7'd0, 5'd12, 1'b1, 64'h01234567_89ABCDEF);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("bp_valid", 64'(resp_valid), 64'd1);
         chk("bp_data", resp_data, 64'h01234567_89ABCDEF);
         chk("bp_ready", 64'(cmd_ready), 64'd0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      chk("bp_done_ready", 64'(cmd_ready), 64'd1);
      chk("bp_done_valid", 64'(resp_valid), 64'd0);

      // Read back the written value; err_timeout still sticky.
      exp_q.push_back('{rd: 5'd13, data: 64'h01234567_89ABCDEF});
      issue(7'd1, 5'd13, 1'b1, 64'd0);
      repeat (3) tick();
      chk("sticky_err", 64'(err_timeout), 64'd1);

      // NOP xd=1: zero data, no register activity.
      w0 = wren_cnt;
      r0 = rq_cnt;
      exp_q.push_back('{rd: 5'd3, data: 64'd0});
      issue(7'd3, 5'd3, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
      chk("nop_valid", 64'(resp_valid), 64'd1);
      tick();
      chk("nop_wren_cnt", 64'(wren_cnt), 64'(w0));
      chk("nop_rq_cnt", 64'(rq_cnt), 64'(r0));

      // WRITE xd=0: one WRITE cycle, no response, then IDLE.
      issue(7'd0, 5'd4, 1'b0, 64'h5555_5555_5555_5555);
      chk("wrnx_wren", 64'(reg_wren), 64'd1);
      tick();
      chk("wrnx_ready", 64'(cmd_ready), 64'd1);
      chk("wrnx_valid", 64'(resp_valid), 64'd0);
      tick();
      chk("wrdata_hold", reg_wrdata, 64'h5555_5555_5555_5555);

      // Reset during READ_WAIT, then a late rdvalid.
      model_respond = 1'b0;
      issue(7'd1, 5'd20, 1'b1, 64'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_ctrl", 64'({cmd_ready, resp_valid, busy, reg_enable, reg_rqvalid, reg_wren}), 64'd0);
      chk("mid_rst_err", 64'(err_timeout), 64'd0);
      tick();
      reset = 1'b0;
      inj_rdvalid = 1'b1;
      #1;
      chk("mid_init_enable", 64'(reg_enable), 64'd1);
      tick();
      chk("mid_idle_ready", 64'(cmd_ready), 64'd1);
      tick();
      inj_rdvalid = 1'b0;
      model_respond = 1'b1;
      repeat (3) tick();
      chk("late_rdvalid_valid", 64'(resp_valid), 64'd0);
      chk("late_rdvalid_busy", 64'(busy), 64'd0);

      // Drain and totals.
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      chk("wren_pulses", 64'(wren_cnt), 64'd3);
      chk("rq_pulses", 64'(rq_cnt), 64'd4);
      chk("enable_pulses", 64'(en_cnt), 64'd2);
      chk("wren_rq_overlap", 64'(overlap_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/myreg_ctrl.md
MYREG_CTRL -- requirements
Module: myreg_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64: data width of register port and command/response data.
REQ-002 SHALL have parameter TIMEOUT, default 15: max cycles to wait for reg_rdvalid after a read request.
REQ-003 SHALL have port clock, in, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, in, 1: reset is synchronous and active-high.
REQ-005 SHALL have port cmd_valid/cmd_ready, in/out, 1/1: command handshake.
REQ-006 SHALL have port cmd_funct, in, 7: command code. 0 = WRITE, 1 = READ, other = NOP.
REQ-007 SHALL have ports cmd_rd, in, 5 and cmd_xd, in, 1: destination tag and response-requested flag.
REQ-008 SHALL have port cmd_rs1, in, XLEN: write data.
REQ-009 SHALL have ports resp_valid/resp_ready, out/in, 1/1: response handshake.
REQ-010 SHALL have ports resp_rd, out, 5 and resp_data, out, XLEN: response tag and data.
REQ-011 SHALL have port busy, out, 1: high in every state except IDLE.
REQ-012 SHALL have port err_timeout, out, 1: sticky read-timeout flag.
REQ-013 SHALL have ports reg_enable, reg_rqvalid, reg_wren, all out, 1: register-side controls.
REQ-014 SHALL have port reg_wrdata, out, XLEN: register-side write data.
REQ-015 SHALL have ports reg_rdvalid, in, 1 and reg_rddata, in, XLEN: register-side read return.

Function
REQ-016 SHALL implement FSM states INIT, IDLE, WRITE, READ_REQ, READ_WAIT, RESP.
REQ-017 SHALL spend exactly one cycle in INIT with reg_enable=1, then enter IDLE. reg_enable SHALL be 0 in every other state.
REQ-018 SHALL drive cmd_ready=1 only in IDLE. A command is accepted on cmd_valid&cmd_ready; funct, rd, xd and rs1 are latched in that cycle.
REQ-019 SHALL handle an accepted WRITE as follows: enter WRITE for exactly one cycle with reg_wren=1 and reg_wrdata=latched rs1. Next state is RESP (resp_data=rs1) if xd=1, else IDLE.
REQ-020 SHALL handle an accepted READ as follows: enter READ_REQ for exactly one cycle with reg_rqvalid=1, then enter READ_WAIT with a cycle counter cleared.
REQ-021 SHALL, in READ_WAIT, on reg_rdvalid=1, capture reg_rddata and go to RESP if xd=1, else IDLE. Minimum read latency from acceptance to resp_valid is 3 cycles.
REQ-022 SHALL, in READ_WAIT, after TIMEOUT cycles without reg_rdvalid, set err_timeout and set captured data to all-ones. Response rules are those of REQ-021.
REQ-023 SHALL handle NOP as follows: no register-side activity. Next state is RESP with resp_data=0 if xd=1, else IDLE.
REQ-024 SHALL, in RESP, hold resp_valid=1 with stable resp_rd/resp_data until resp_ready=1, then return to IDLE. resp_ready outside RESP is ignored.
REQ-025 SHALL ignore reg_rdvalid outside READ_WAIT. A rdvalid coinciding with the timeout cycle SHALL count as success; err_timeout is not set.
REQ-026 SHALL hold reg_wrdata at last written value when reg_wren=0.
REQ-027 SHALL ensure reg_rqvalid and reg_wren are never high in the same cycle.

Reset
REQ-028 SHALL, on reset, enter INIT; counter=0; err_timeout=0; latched command cleared.
REQ-029 SHALL, during reset, drive all outputs to 0: cmd_ready, resp_valid, resp_rd, resp_data, busy, reg_enable, reg_rqvalid, reg_wren, reg_wrdata.
REQ-030 SHALL, on reset mid-operation, drop the pending command and any unaccepted response, then re-run INIT.

Structure
REQ-031 SHALL place the following in shared package myreg_pkg: state enum, FUNCT_WRITE/FUNCT_READ constants, and default XLEN.
REQ-032 SHALL implement the timeout counter as sub-module myreg_timeout (inputs clear, run; output expired).

Verification
REQ-033 SHALL cover reset release: INIT one cycle with reg_enable=1, then cmd_ready=1. All other outputs 0 during reset.
REQ-034 SHALL cover WRITE then READ. WRITE rs1=0xDEADBEEF_00000001, xd=1, rd=5 -> one wren pulse; resp rd=5, data=0xDEADBEEF_00000001. READ xd=1, rd=7, model returns rdvalid 1 cycle after rqvalid -> resp rd=7, data=0xDEADBEEF_00000001, 3 cycles after acceptance.
REQ-035 SHALL cover read timeout. Model never asserts rdvalid -> after 15 cycles, resp_data=0xFFFFFFFF_FFFFFFFF and err_timeout=1 sticky until reset.
REQ-036 SHALL cover backpressure: resp_ready=0 for 4 cycles -> resp_valid and data stable, cmd_ready=0. Handshake completes when resp_ready rises.
REQ-037 SHALL cover NOP and xd=0. funct=3, xd=1 -> resp_data=0 with no reg activity. WRITE xd=0 -> no resp_valid; IDLE after 1 cycle.
REQ-038 SHALL cover reset asserted in READ_WAIT: no response, returns to INIT, and a late rdvalid is ignored.
